control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 70 +++++++
 rtl/control_decode.sv | 203 ++++++++++++++++++++
 rtl/control_unit.sv | 91 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, control-step encoding and the control-word layout.
// Build option: CONTROL_UNIT_MULDIV_EN enables the mul/div control sequence.
package cpu_pkg;

   typedef enum logic [3:0] {
      ST_RST,
      ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7,
      ST_HALT
   } state_t;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_BR   = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_JAL  = 5'b10101;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   typedef struct packed {
      logic       run;
      logic [4:0] opcode;
      logic       gra, grb, grc, rin, rout, baout;
      logic       pcin, irin, marin, mdrin, yin, zin, hiin, loin, conin, outportin;
      logic       pcout, mdrout, zhighout, zlowout, hiout, loout, inportout, cout;
      logic       read, write, incpc;
   } ctrl_t;

   // Final execute step of each instruction; ST_T2 means no execute steps (nop-like).
   function automatic state_t last_step(input logic [4:0] op);
      state_t s;
      s = ST_T2;
      case (op) inside
         OP_LD, OP_ST:                          s = ST_T7;
         OP_LDI, [OP_ADD:OP_SHL], [OP_ADDI:OP_ORI]: s = ST_T5;
         OP_NEG, OP_NOT, OP_JAL:                s = ST_T4;
         OP_BR:                                 s = ST_T6;
         OP_JR, [OP_IN:OP_MFLO]:                s = ST_T3;
`ifdef CONTROL_UNIT_MULDIV_EN
         OP_MUL, OP_DIV:                        s = ST_T6;
`else
         OP_MUL, OP_DIV:                        s = ST_T2;
`endif
         OP_HALT:                               s = ST_HALT;
         default:                               s = ST_T2;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/control_decode.sv
// Moore output decode: control word from current step and instruction opcode.
// Build option: CONTROL_UNIT_MULDIV_EN adds the mul/div strobes.
module control_decode
   import cpu_pkg::*;
(
   input  state_t     i_state,
   input  logic [4:0] i_op,
   input  logic       i_con_ff,
   output ctrl_t      o_ctrl
);

   always_comb begin
      o_ctrl     = '0;
      o_ctrl.run = (i_state != ST_RST) && (i_state != ST_HALT);
      case (i_state)
         ST_T0: begin
            o_ctrl.pcout  = 1'b1;
            o_ctrl.marin  = 1'b1;
            o_ctrl.incpc  = 1'b1;
            o_ctrl.zin    = 1'b1;
            o_ctrl.opcode = OP_ADD;
         end
         ST_T1: begin
            o_ctrl.zlowout = 1'b1;
            o_ctrl.pcin    = 1'b1;
            o_ctrl.read    = 1'b1;
            o_ctrl.mdrin   = 1'b1;
         end
         ST_T2: begin
            o_ctrl.mdrout = 1'b1;
            o_ctrl.irin   = 1'b1;
         end
         ST_T3: begin
            case (i_op) inside
               [OP_ADD:OP_SHL], [OP_ADDI:OP_ORI]: begin
                  o_ctrl.grb  = 1'b1;
                  o_ctrl.rout = 1'b1;
                  o_ctrl.yin  = 1'b1;
               end
               OP_LD, OP_LDI, OP_ST: begin
                  o_ctrl.grb   = 1'b1;
                  o_ctrl.baout = 1'b1;
                  o_ctrl.yin   = 1'b1;
               end
               OP_NEG, OP_NOT: begin
                  o_ctrl.grb    = 1'b1;
                  o_ctrl.rout   = 1'b1;
                  o_ctrl.zin    = 1'b1;
                  o_ctrl.opcode = i_op;
               end
`ifdef CONTROL_UNIT_MULDIV_EN
               OP_MUL, OP_DIV: begin
                  o_ctrl.gra  = 1'b1;
                  o_ctrl.rout = 1'b1;
                  o_ctrl.yin  = 1'b1;
               end
`endif
               OP_BR: begin
                  o_ctrl.gra   = 1'b1;
                  o_ctrl.rout  = 1'b1;
                  o_ctrl.conin = 1'b1;
               end
               OP_JR: begin
                  o_ctrl.gra  = 1'b1;
                  o_ctrl.rout = 1'b1;
                  o_ctrl.pcin = 1'b1;
               end
               OP_JAL: begin
                  o_ctrl.pcout = 1'b1;
                  o_ctrl.grb   = 1'b1;
                  o_ctrl.rin   = 1'b1;
               end
               OP_IN: begin
                  o_ctrl.inportout = 1'b1;
                  o_ctrl.gra       = 1'b1;
                  o_ctrl.rin       = 1'b1;
               end
               OP_OUT: begin
                  o_ctrl.gra       = 1'b1;
                  o_ctrl.rout      = 1'b1;
                  o_ctrl.outportin = 1'b1;
               end
               OP_MFHI: begin
                  o_ctrl.hiout = 1'b1;
                  o_ctrl.gra   = 1'b1;
                  o_ctrl.rin   = 1'b1;
               end
               OP_MFLO: begin
                  o_ctrl.loout = 1'b1;
                  o_ctrl.gra   = 1'b1;
                  o_ctrl.rin   = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T4: begin
            case (i_op) inside
               [OP_ADD:OP_SHL]: begin
                  o_ctrl.grc    = 1'b1;
                  o_ctrl.rout   = 1'b1;
                  o_ctrl.zin    = 1'b1;
                  o_ctrl.opcode = i_op;
               end
               [OP_ADDI:OP_ORI]: begin
                  o_ctrl.cout   = 1'b1;
                  o_ctrl.zin    = 1'b1;
                  o_ctrl.opcode = i_op;
               end
               OP_LD, OP_LDI, OP_ST: begin
                  o_ctrl.cout   = 1'b1;
                  o_ctrl.zin    = 1'b1;
                  o_ctrl.opcode = OP_ADD;
               end
               OP_NEG, OP_NOT: begin
                  o_ctrl.zlowout = 1'b1;
                  o_ctrl.gra     = 1'b1;
                  o_ctrl.rin     = 1'b1;
               end
`ifdef CONTROL_UNIT_MULDIV_EN
               OP_MUL, OP_DIV: begin
                  o_ctrl.grb    = 1'b1;
                  o_ctrl.rout   = 1'b1;
                  o_ctrl.zin    = 1'b1;
                  o_ctrl.opcode = i_op;
               end
`endif
               OP_BR: begin
                  o_ctrl.pcout = 1'b1;
                  o_ctrl.yin   = 1'b1;
               end
               OP_JAL: begin
                  o_ctrl.gra  = 1'b1;
                  o_ctrl.rout = 1'b1;
                  o_ctrl.pcin = 1'b1;
               end
               default: ;
            endcase
         end
         ST_T5: begin
            case (i_op) inside
               [OP_ADD:OP_SHL], [OP_ADDI:OP_ORI], OP_LDI: begin
                  o_ctrl.zlowout = 1'b1;
                  o_ctrl.gra     = 1'b1;
                  o_ctrl.rin     = 1'b1;
               end
               OP_LD, OP_ST: begin
                  o_ctrl.zlowout = 1'b1;
                  o_ctrl.marin   = 1'b1;
               end
`ifdef CONTROL_UNIT_MULDIV_EN
               OP_MUL, OP_DIV: begin
                  o_ctrl.zlowout = 1'b1;
                  o_ctrl.loin    = 1'b1;
               end
`endif
               OP_BR: begin
                  o_ctrl.cout   = 1'b1;
                  o_ctrl.zin    = 1'b1;
                  o_ctrl.opcode = OP_ADD;
               end
               default: ;
            endcase
         end
         ST_T6: begin
            case (i_op) inside
               OP_LD: begin
                  o_ctrl.read  = 1'b1;
                  o_ctrl.mdrin = 1'b1;
               end
               OP_ST: begin
                  o_ctrl.gra   = 1'b1;
                  o_ctrl.rout  = 1'b1;
                  o_ctrl.mdrin = 1'b1;
               end
`ifdef CONTROL_UNIT_MULDIV_EN
               OP_MUL, OP_DIV: begin
                  o_ctrl.zhighout = 1'b1;
                  o_ctrl.hiin     = 1'b1;
               end
`endif
               OP_BR: begin
                  o_ctrl.zlowout = i_con_ff;
                  o_ctrl.pcin    = i_con_ff;
               end
               default: ;
            endcase
         end
         ST_T7: begin
            case (i_op) inside
               OP_LD: begin
                  o_ctrl.mdrout = 1'b1;
                  o_ctrl.gra    = 1'b1;
                  o_ctrl.rin    = 1'b1;
               end
               OP_ST:   o_ctrl.write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Instruction-sequencing control unit: step register and next-step logic; strobes come from control_decode.
// Build option: CONTROL_UNIT_MULDIV_EN enables the mul/div sequence (otherwise those opcodes act as nop).
module control_unit
   import cpu_pkg::*;
(
   input  logic        Clock,
   input  logic        clear_n,
   input  logic [31:0] IR,
   input  logic        CON_FF,
   output logic        Run,
   output logic [4:0]  opcode,
   output logic        Gra, Grb, Grc, Rin, Rout, BAout,
   output logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, CONin, Outportin,
   output logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Inportout, Cout,
   output logic        Read, Write, IncPC
);

   state_t r_state;
   state_t w_next_state;
   state_t w_last;
   ctrl_t  w_ctrl;
   logic   w_ir_unused;

   assign w_ir_unused = ^IR[26:0];

   always_ff @(posedge Clock or negedge clear_n) begin
      if (!clear_n) r_state <= ST_RST;
      else          r_state <= w_next_state;
   end

   // After the final execute step of the current opcode the sequence wraps to T0.
   always_comb begin
      w_last       = last_step(IR[31:27]);
      w_next_state = r_state;
      case (r_state)
         ST_RST:  w_next_state = ST_T0;
         ST_T0:   w_next_state = ST_T1;
         ST_T1:   w_next_state = ST_T2;
         ST_T2: begin
            if (w_last == ST_HALT)    w_next_state = ST_HALT;
            else if (w_last == ST_T2) w_next_state = ST_T0;
            else                      w_next_state = ST_T3;
         end
         ST_T3:   w_next_state = (w_last == ST_T3) ? ST_T0 : ST_T4;
         ST_T4:   w_next_state = (w_last == ST_T4) ? ST_T0 : ST_T5;
         ST_T5:   w_next_state = (w_last == ST_T5) ? ST_T0 : ST_T6;
         ST_T6:   w_next_state = (w_last == ST_T6) ? ST_T0 : ST_T7;
         ST_T7:   w_next_state = ST_T0;
         ST_HALT: w_next_state = ST_HALT;
         default: w_next_state = ST_RST;
      endcase
   end

   control_decode u_decode (
      .i_state  (r_state),
      .i_op     (IR[31:27]),
      .i_con_ff (CON_FF),
      .o_ctrl   (w_ctrl)
   );

   assign Run       = w_ctrl.run;
   assign opcode    = w_ctrl.opcode;
   assign Gra       = w_ctrl.gra;
   assign Grb       = w_ctrl.grb;
   assign Grc       = w_ctrl.grc;
   assign Rin       = w_ctrl.rin;
   assign Rout      = w_ctrl.rout;
   assign BAout     = w_ctrl.baout;
   assign PCin      = w_ctrl.pcin;
   assign IRin      = w_ctrl.irin;
   assign MARin     = w_ctrl.marin;
   assign MDRin     = w_ctrl.mdrin;
   assign Yin       = w_ctrl.yin;
   assign Zin       = w_ctrl.zin;
   assign HIin      = w_ctrl.hiin;
   assign LOin      = w_ctrl.loin;
   assign CONin     = w_ctrl.conin;
   assign Outportin = w_ctrl.outportin;
   assign PCout     = w_ctrl.pcout;
   assign MDRout    = w_ctrl.mdrout;
   assign Zhighout  = w_ctrl.zhighout;
   assign Zlowout   = w_ctrl.zlowout;
   assign HIout     = w_ctrl.hiout;
   assign LOout     = w_ctrl.loout;
   assign Inportout = w_ctrl.inportout;
   assign Cout      = w_ctrl.cout;
   assign Read      = w_ctrl.read;
   assign Write     = w_ctrl.write;
   assign IncPC     = w_ctrl.incpc;

endmodule
